// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, fault codes, default widths and issuer FSM states.
// Imported by the command issuer and anything that needs to decode ALU selects.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 4;

  localparam logic [7:0] ALU_ERR_CODE = 8'hAC;
  localparam logic [7:0] DIV0_CODE    = 8'hFF;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_DIV = 4'b0011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a registered ALU and returns a tagged response.
// Latency: response valid ALU_LATENCY+1 edges after accept; divide-by-zero responds on the accept edge.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. ALU_ISSUER_STATS_EN adds counters.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int TAG_W       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [15:0]       stat_cmds,
  output logic [15:0]       stat_errs
`endif
);

  localparam int CNT_W = $clog2(ALU_LATENCY + 1);
  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(ALU_ADD);
  localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(ALU_DIV);

  issuer_state_e      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  alu_a_q;
  logic [DATA_W-1:0]  alu_b_q;
  logic [SEL_W-1:0]   alu_sel_q;
  logic [TAG_W-1:0]   tag_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_carry_q;
  logic               rsp_err_q;
  logic [TAG_W-1:0]   rsp_tag_q;

  logic cmd_div0;
  logic sel_legal;

  assign cmd_div0  = (cmd_op == OP_DIV) && (cmd_b == '0);
  assign sel_legal = (alu_sel_q <= OP_DIV);

  // Ready is forced low while reset is held so nothing is accepted in a reset cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_div0) begin
              // Divide by zero never reaches the ALU; operands keep their old values.
              rsp_data_q  <= '1;
              rsp_carry_q <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_tag_q   <= cmd_tag;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              alu_a_q   <= cmd_a;
              alu_b_q   <= cmd_b;
              alu_sel_q <= cmd_op;
              tag_q     <= cmd_tag;
              cnt_q     <= CNT_W'(ALU_LATENCY);
              state_q   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rsp_data_q  <= alu_out;
            rsp_carry_q <= (alu_sel_q == OP_ADD) && alu_carry;
            rsp_err_q   <= !sel_legal;
            rsp_tag_q   <= tag_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tag   = rsp_tag_q;

`ifdef ALU_ISSUER_STATS_EN
  logic        rsp_fire;
  logic [15:0] stat_cmds_q, stat_cmds_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  assign rsp_fire = rsp_valid_q && rsp_ready;

  // Saturating counters, both advanced on the response handshake.
  always_comb begin
    stat_cmds_d = stat_cmds_q;
    stat_errs_d = stat_errs_q;
    if (rsp_fire && (stat_cmds_q != 16'hFFFF)) begin
      stat_cmds_d = stat_cmds_q + 16'd1;
    end
    if (rsp_fire && rsp_err_q && (stat_errs_q != 16'hFFFF)) begin
      stat_errs_d = stat_errs_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_cmds_q <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_cmds_q <= stat_cmds_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign stat_cmds = stat_cmds_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a one-stage registered ALU model attached.
module tb_alu_cmd_issuer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'd0;
  logic [7:0] cmd_a = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic [3:0] cmd_tag = 4'd0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out = 8'd0;
  logic       alu_carry = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_err;
  logic [3:0] rsp_tag;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
    logic [7:0] d;
    logic       c;
    logic       e;
  } vec_t;

  vec_t vecs[6];

  alu_cmd_issuer #(.DATA_W(8), .SEL_W(4), .TAG_W(4), .ALU_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  always #5 clock = ~clock;

  // Registered ALU: carry is always bit 8 of A+B regardless of the select.
  logic [8:0] alu_sum;
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  always @(posedge clock) begin
    alu_carry <= alu_sum[8];
    case (alu_sel)
      4'd0:    alu_out <= alu_sum[7:0];
      4'd1:    alu_out <= alu_a - alu_b;
      4'd2:    alu_out <= alu_a * alu_b;
      4'd3:    alu_out <= (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
      default: alu_out <= 8'hAC;
    endcase
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL %s_timeout rsp_valid=%b want=1", name, rsp_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0; cmd_valid = 1'b1;
    step(); step();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b want=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    total++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin bad++; $display("FAIL rst_alu got=%h want=0", {alu_a, alu_b, alu_sel}); end
    total++; if ({rsp_data, rsp_carry, rsp_err, rsp_tag} !== 14'h0) begin bad++; $display("FAIL rst_rsp got=%h want=0", {rsp_data, rsp_carry, rsp_err, rsp_tag}); end
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", cmd_ready); end
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    issue(4'd0, 8'd200, 8'd100, 4'd3);
    total++; if (alu_a !== 8'd200 || alu_b !== 8'd100 || alu_sel !== 4'd0) begin bad++; $display("FAIL add_drive got=%0d,%0d,%0d want=200,100,0", alu_a, alu_b, alu_sel); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL add_busy got=%b want=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_early0 got=%b want=0", rsp_valid); end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_early1 got=%b want=0", rsp_valid); end
    step();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", rsp_valid); end
    total++; if (rsp_data !== 8'h2C) begin bad++; $display("FAIL add_data got=%h want=2c", rsp_data); end
    total++; if (rsp_carry !== 1'b1) begin bad++; $display("FAIL add_carry got=%b want=1", rsp_carry); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL add_err got=%b want=0", rsp_err); end
    total++; if (rsp_tag !== 4'd3) begin bad++; $display("FAIL add_tag got=%0d want=3", rsp_tag); end
    step();
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL add_done got=%b/%b want=0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_ops();
    vecs[0] = '{4'd1, 8'd5,   8'd10,  4'd1,  8'hFB, 1'b0, 1'b0};
    vecs[1] = '{4'd1, 8'd200, 8'd100, 4'd2,  8'h64, 1'b0, 1'b0};
    vecs[2] = '{4'd3, 8'd100, 8'd7,   4'd8,  8'h0E, 1'b0, 1'b0};
    vecs[3] = '{4'd7, 8'd1,   8'd1,   4'd5,  8'hAC, 1'b0, 1'b1};
    vecs[4] = '{4'hF, 8'd200, 8'd100, 4'hA,  8'hAC, 1'b0, 1'b1};
    vecs[5] = '{4'd2, 8'd16,  8'd17,  4'd4,  8'h10, 1'b0, 1'b0};
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_rsp("ops");
      total++; if (rsp_data !== vecs[i].d) begin bad++; $display("FAIL ops%0d_data got=%h want=%h", i, rsp_data, vecs[i].d); end
      total++; if (rsp_carry !== vecs[i].c) begin bad++; $display("FAIL ops%0d_carry got=%b want=%b", i, rsp_carry, vecs[i].c); end
      total++; if (rsp_err !== vecs[i].e) begin bad++; $display("FAIL ops%0d_err got=%b want=%b", i, rsp_err, vecs[i].e); end
      total++; if (rsp_tag !== vecs[i].tag) begin bad++; $display("FAIL ops%0d_tag got=%h want=%h", i, rsp_tag, vecs[i].tag); end
      step();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ops%0d_drop got=%b want=0", i, rsp_valid); end
    end
  endtask

  task automatic test_div0();
    rsp_ready = 1'b0;
    issue(4'd3, 8'd10, 8'd0, 4'd9);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL div0_valid got=%b want=1", rsp_valid); end
    total++; if (alu_a !== 8'd16 || alu_b !== 8'd17 || alu_sel !== 4'd2) begin bad++; $display("FAIL div0_alu_held got=%0d,%0d,%0d want=16,17,2", alu_a, alu_b, alu_sel); end
    total++; if (rsp_data !== 8'hFF) begin bad++; $display("FAIL div0_data got=%h want=ff", rsp_data); end
    total++; if (rsp_err !== 1'b1 || rsp_carry !== 1'b0) begin bad++; $display("FAIL div0_flags got=err%b,c%b want=err1,c0", rsp_err, rsp_carry); end
    total++; if (rsp_tag !== 4'd9) begin bad++; $display("FAIL div0_tag got=%0d want=9", rsp_tag); end
    rsp_ready = 1'b1;
    step();
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL div0_done got=%b/%b want=0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(4'd0, 8'd1, 8'd1, 4'd6);
    cmd_op = 4'd0; cmd_a = 8'd3; cmd_b = 8'd4; cmd_tag = 4'd7; cmd_valid = 1'b1;
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h02 || rsp_tag !== 4'd6) begin bad++; $display("FAIL bp_hold%0d got=v%b d%h t%0d want=v1 d02 t6", i, rsp_valid, rsp_data, rsp_tag); end
      total++; if (cmd_ready !== 1'b0 || alu_a !== 8'd1) begin bad++; $display("FAIL bp_block%0d got=rdy%b a%0d want=rdy0 a1", i, cmd_ready, alu_a); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%b want=0/1", rsp_valid, cmd_ready); end
    step();
    cmd_valid = 1'b0;
    total++; if (alu_a !== 8'd3 || alu_b !== 8'd4 || cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%0d,%0d,rdy%b want=3,4,rdy0", alu_a, alu_b, cmd_ready); end
    wait_rsp("bp2");
    total++; if (rsp_data !== 8'h07 || rsp_tag !== 4'd7) begin bad++; $display("FAIL bp_next_rsp got=%h/%0d want=07/7", rsp_data, rsp_tag); end
    step();
  endtask

  task automatic test_reset_in_wait();
    rsp_ready = 1'b1;
    issue(4'd0, 8'd50, 8'd60, 4'd2);
    reset = 1'b1;
    step();
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL rw_in_reset got=%b/%b want=0/0", rsp_valid, cmd_ready); end
    total++; if (alu_a !== 8'd0) begin bad++; $display("FAIL rw_alu_a got=%0d want=0", alu_a); end
    reset = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rw_ready got=%b want=1", cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rw_no_rsp%0d got=%b want=0", i, rsp_valid); end
    end
    issue(4'd0, 8'd3, 8'd4, 4'hB);
    wait_rsp("rw");
    total++; if (rsp_data !== 8'h07 || rsp_tag !== 4'hB || rsp_carry !== 1'b0) begin bad++; $display("FAIL rw_rsp got=%h/%h/%b want=07/b/0", rsp_data, rsp_tag, rsp_carry); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_div0();
    test_backpressure();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
